// File: rtl/inst_mem_loader_pkg.sv
// inst_loader_pkg: shared types and constants for the instruction memory
// loader and its word serializer.
package inst_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BEAT_W = 2;

  typedef logic [BEAT_W-1:0] beat_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    FIN
  } state_t;

endpackage

// File: rtl/inst_mem_loader_if.sv
// inst_mem_loader_if: valid/ready word stream feeding the loader.
// Master is the program source, slave is the loader.
interface inst_mem_loader_if #(
  parameter int SIZE = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [4*SIZE-1:0] in_word;
  logic              in_last;

  modport master (
    output in_valid,
    output in_word,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_word,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/inst_mem_loader_word_serializer.sv
// word_serializer: holds one word and emits it MSB byte first,
// one byte per shift, flagging the fourth beat.
module word_serializer
  import inst_loader_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_load,
  input  logic                             i_shift,
  input  logic [BYTES_PER_WORD*SIZE-1:0]   i_word,
  output logic [SIZE-1:0]                  o_byte,
  output logic                             o_last_beat
);

  localparam int WW = BYTES_PER_WORD * SIZE;

  logic [WW-1:0] r_sreg;
  beat_t         r_beat;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sreg <= '0;
      r_beat <= '0;
    end else if (i_load) begin
      r_sreg <= i_word;
      r_beat <= '0;
    end else if (i_shift) begin
      r_sreg <= r_sreg << SIZE;
      r_beat <= r_beat + 1'b1;
    end
  end

  assign o_byte      = r_sreg[WW-1 -: SIZE];
  assign o_last_beat = (r_beat == beat_t'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: writes streamed words big-endian into byte memory.
// Define INST_MEM_LOADER_CHECKSUM_EN to add the o_checksum output.
module inst_mem_loader
  import inst_loader_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int DEPTH = 256
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [4*SIZE-1:0]   i_start_adr,
  inst_mem_loader_if.slave    s_in,
  output logic                o_mem_we,
  output logic [4*SIZE-1:0]   o_mem_adr,
  output logic [SIZE-1:0]     o_mem_data,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic [4*SIZE-1:0]   o_word_count
`ifdef INST_MEM_LOADER_CHECKSUM_EN
  ,
  output logic [4*SIZE-1:0]   o_checksum
`endif
);

  localparam int WW = BYTES_PER_WORD * SIZE;

  state_t        r_state;
  state_t        w_next;
  logic [WW-1:0] r_ptr;
  logic [WW-1:0] r_wc;
  logic          r_err;
  logic          r_last;

  logic          w_ready;
  logic          w_load;
  logic          w_shift;
  logic          w_reject;
  logic          w_acc_start;
  logic          w_bad_start;
  logic          w_fits;
  logic          w_last_beat;
  logic [WW:0]   w_end;
  logic [SIZE-1:0] w_byte;

  // Widened so a pointer near the top of the address space cannot wrap.
  assign w_end  = {1'b0, r_ptr} + (WW+1)'(BYTES_PER_WORD);
  assign w_fits = (w_end <= (WW+1)'(DEPTH));

  word_serializer #(.SIZE(SIZE)) u_ser (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (w_load),
    .i_shift     (w_shift),
    .i_word      (s_in.in_word),
    .o_byte      (w_byte),
    .o_last_beat (w_last_beat)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_ready     = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_reject    = 1'b0;
    w_acc_start = 1'b0;
    w_bad_start = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_mem_we    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          if (i_start_adr[1:0] == 2'b00) begin
            w_acc_start = 1'b1;
            w_next      = LOAD;
          end else begin
            w_bad_start = 1'b1;
          end
        end
      end
      LOAD: begin
        o_busy  = 1'b1;
        w_ready = 1'b1;
        if (s_in.in_valid) begin
          if (w_fits) begin
            w_load = 1'b1;
            w_next = WRITE;
          end else begin
            w_reject = 1'b1;
            w_next   = IDLE;
          end
        end
      end
      WRITE: begin
        o_busy   = 1'b1;
        o_mem_we = 1'b1;
        w_shift  = 1'b1;
        if (w_last_beat) w_next = r_last ? FIN : LOAD;
      end
      FIN: begin
        o_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr  <= '0;
      r_wc   <= '0;
      r_err  <= 1'b0;
      r_last <= 1'b0;
    end else begin
      if (w_acc_start) begin
        r_ptr <= i_start_adr;
        r_wc  <= '0;
        r_err <= 1'b0;
      end
      if (w_bad_start || w_reject) r_err <= 1'b1;
      if (w_load) r_last <= s_in.in_last;
      if (w_shift) begin
        r_ptr <= r_ptr + 1'b1;
        if (w_last_beat) r_wc <= r_wc + 1'b1;
      end
    end
  end

`ifdef INST_MEM_LOADER_CHECKSUM_EN
  logic [WW-1:0] r_ck;

  always_ff @(posedge i_clk) begin
    if (i_rst)            r_ck <= '0;
    else if (w_acc_start) r_ck <= '0;
    else if (w_load)      r_ck <= r_ck + s_in.in_word;
  end

  assign o_checksum = r_ck;
`endif

  assign s_in.in_ready = w_ready;
  assign o_mem_adr     = o_mem_we ? r_ptr  : '0;
  assign o_mem_data    = o_mem_we ? w_byte : '0;
  assign o_err         = r_err;
  assign o_word_count  = r_wc;

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Writer side of the byte-wide instruction memory.
- Accepts 32-bit instruction words over a valid/ready stream and writes each one as four big-endian bytes into consecutive byte addresses.
- Byte layout: word bits [4*SIZE-1:3*SIZE] go to the lowest address.
- Sits between the boot/test program source and the instruction memory's write port; the fetch path reads back what this block writes.

Parameters:
- SIZE, 8, byte width in bits; word width is 4*SIZE.
- DEPTH, 256, memory size in bytes; highest legal byte address is DEPTH-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse, begins a load session (honoured only in IDLE)
- start_adr  input  4*SIZE  byte base address, latched on start
- in_valid  input  1  in_word/in_last valid
- in_ready  output  1  loader can accept a word this cycle
- in_word  input  4*SIZE  instruction word
- in_last  input  1  marks the final word of the session
- mem_we  output  1  byte write strobe
- mem_adr  output  4*SIZE  byte address
- mem_data  output  SIZE  byte data
- busy  output  1  session in progress
- done  output  1  one-cycle pulse, session completed without error
- err  output  1  sticky error flag, cleared on next accepted start
- word_count  output  4*SIZE  words fully written in the current or last session

Behaviour:
- Reset values: all outputs 0; state IDLE; internal pointer, shift register and beat counter all 0.
- States: IDLE, LOAD, WRITE, FIN.
- IDLE:
  - in_ready=0, busy=0.
  - On start with start_adr[1:0]==0: latch the pointer, clear err and word_count, go to LOAD.
  - On start with start_adr[1:0]!=0: set err=1, stay in IDLE, no writes.
- LOAD:
  - busy=1, in_ready=1.
  - A handshake (in_valid&&in_ready) captures in_word and in_last.
  - If pointer+4 > DEPTH: set err=1, perform no writes, return to IDLE. done is not pulsed.
  - Otherwise go to WRITE with beat=0.
- WRITE:
  - in_ready=0; source must hold data, and nothing is accepted.
  - Each cycle: mem_we=1, mem_adr=pointer, mem_data=top byte of the shift register.
  - Next cycle: shift left by SIZE, pointer+1, beat+1.
  - After beat 3: word_count+1. Go to FIN if the captured in_last was set, else LOAD.
- Timing: a word accepted at cycle N is written at cycles N+1..N+4; the next word can be accepted at N+5.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE.
- start while busy is ignored.
- Pointer arithmetic is 4*SIZE bits; the overflow check above prevents wrap.
- mem_adr and mem_data are don't-care when mem_we=0; they are driven to 0.
- Reset mid-session:
  - Next cycle: mem_we=0, busy=0, in_ready=0.
  - Bytes already written remain in memory.
  - err and word_count return to 0.

Optional Feature:
- Macro: INST_MEM_LOADER_CHECKSUM_EN.
- Defined:
  - Extra output checksum [4*SIZE-1:0].
  - Cleared on accepted start.
  - On each handshake that is not rejected, checksum = checksum + in_word mod 2^(4*SIZE).
  - Value holds after done.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package inst_loader_pkg:
  - State enum (IDLE, LOAD, WRITE, FIN).
  - BYTES_PER_WORD=4.
  - Beat counter width 2.
- Sub-module word_serializer:
  - Loads a 4*SIZE word and emits SIZE-bit bytes MSB-first with a 2-bit beat counter.
  - Signals last_beat.
  - Controller FSM stays in the top module.

Test Plan:
- Basic load: start_adr=0; words 0x20010050, 0x200A0001, 0x20020000 (last on third) -> writes at addr 0..11 = 20 01 00 50 20 0A 00 01 20 02 00 00. done pulses one cycle after the addr-11 write; word_count=3; err=0.
- Backpressure: in_valid held high with the next word during WRITE -> in_ready=0 for 4 cycles and no double accept. Exactly 4 mem_we per word; 5-cycle cadence.
- Unaligned start: start_adr=0x3 -> err=1 next cycle, no mem_we, busy=0. A following start_adr=0x4 clears err.
- Overflow: start_adr=252 with two words -> bytes 252..255 written, second word rejected. err=1, done never pulses, word_count=1, returns to IDLE.
- Reset mid-write: rst asserted at beat 2 -> next cycle mem_we=0, busy=0, in_ready=0, word_count=0. A new session then works normally.
- Checksum (macro defined): words 0xFFFFFFFF, 0x00000002 -> checksum=0x00000001 after done.
